i2c_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares the single I2C master among the four swerve-module angle controllers. Each controller raises a level request for a 12-bit encoder angle. The arbiter selects the channel on the TCA9548A I2C mux, writes the encoder angle-register pointer and reads two bytes. It then returns the angle and a one-cycle ack to the granted requester. It sits between the per-wheel `pwm_ctrl` instances and the shared I2C byte engine.

---
 rtl/i2c_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_i2c_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master among NUM_REQ encoder readers.
// Optional mux-channel cache enabled by defining I2C_ARB_CHAN_CACHE_EN.
//
// state      | meaning
// -----------+----------------------------------------------
// S_IDLE     | waiting for any request
// S_ARB      | round-robin pick, latch gnt/last
// S_MUX_WR   | issue mux channel-select write
// S_MUX_WAIT | wait for mux write completion
// S_PTR_WR   | issue encoder angle-register pointer write
// S_PTR_WAIT | wait for pointer write completion
// S_RD       | issue two-byte angle read
// S_RD_WAIT  | wait for read data
// S_RESP     | ack with angle
// S_FAIL     | ack with err, angle 0
module i2c_arbiter #(
  parameter int         NUM_REQ        = 4,
  parameter logic [6:0] MUX_ADDR       = 7'h70,
  parameter logic [6:0] ENC_ADDR       = 7'h36,
  parameter logic [7:0] ANGLE_REG      = 8'h0E,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [11:0]        angle,
  output logic               err,
  output logic               mst_start,
  output logic               mst_rw,
  output logic [6:0]         mst_addr,
  output logic [7:0]         mst_wdata,
  output logic [1:0]         mst_nbytes,
  input  logic               mst_busy,
  input  logic               mst_done,
  input  logic               mst_nack,
  input  logic [15:0]        mst_rdata
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_MUX_WR, S_MUX_WAIT, S_PTR_WR,
    S_PTR_WAIT, S_RD, S_RD_WAIT, S_RESP, S_FAIL
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gnt, last, win, idx;
  logic          found;
  logic [TW-1:0] tmr;
  logic          tmr_tc;
  logic [11:0]   angle_q;
  logic          cache_hit;
  logic          rdata_unused;

  // Encoder angle is 12 bits; the top nibble of the first byte carries nothing useful.
  assign rdata_unused = &mst_rdata[15:12];
  assign tmr_tc = (tmr == '0);

  always_comb begin
    win   = last;
    found = 1'b0;
    idx   = last;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (idx == GW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

`ifdef I2C_ARB_CHAN_CACHE_EN
  logic          cache_vld;
  logic [GW-1:0] cache_ch;

  assign cache_hit = cache_vld && (cache_ch == win);

  always_ff @(posedge clock) begin
    if (reset) begin
      cache_vld <= 1'b0;
      cache_ch  <= '0;
    end else if (state == S_FAIL) begin
      cache_vld <= 1'b0;
    end else if (state == S_MUX_WAIT && mst_done && !mst_nack) begin
      cache_vld <= 1'b1;
      cache_ch  <= gnt;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      gnt     <= '0;
      last    <= GW'(NUM_REQ - 1);
      tmr     <= TMR_LOAD;
      angle_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_ARB && found) begin
        gnt  <= win;
        last <= win;
      end
      // Reload on every state change so each handshake state gets a full budget.
      if (state_nxt != state)
        tmr <= TMR_LOAD;
      else if (!tmr_tc)
        tmr <= tmr - 1'b1;
      if (state == S_RD_WAIT && mst_done && !mst_nack)
        angle_q <= {mst_rdata[11:8], mst_rdata[7:0]};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (|req) state_nxt = S_ARB;
      S_ARB:      if (!found)        state_nxt = S_IDLE;
                  else if (cache_hit) state_nxt = S_PTR_WR;
                  else               state_nxt = S_MUX_WR;
      S_MUX_WR:   if (!mst_busy)     state_nxt = S_MUX_WAIT;
                  else if (tmr_tc)   state_nxt = S_FAIL;
      S_MUX_WAIT: if (mst_done)      state_nxt = mst_nack ? S_FAIL : S_PTR_WR;
                  else if (tmr_tc)   state_nxt = S_FAIL;
      S_PTR_WR:   if (!mst_busy)     state_nxt = S_PTR_WAIT;
                  else if (tmr_tc)   state_nxt = S_FAIL;
      S_PTR_WAIT: if (mst_done)      state_nxt = mst_nack ? S_FAIL : S_RD;
                  else if (tmr_tc)   state_nxt = S_FAIL;
      S_RD:       if (!mst_busy)     state_nxt = S_RD_WAIT;
                  else if (tmr_tc)   state_nxt = S_FAIL;
      S_RD_WAIT:  if (mst_done)      state_nxt = mst_nack ? S_FAIL : S_RESP;
                  else if (tmr_tc)   state_nxt = S_FAIL;
      S_RESP:     state_nxt = S_IDLE;
      S_FAIL:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack        = '0;
    err        = 1'b0;
    angle      = '0;
    mst_start  = 1'b0;
    mst_rw     = 1'b0;
    mst_addr   = '0;
    mst_wdata  = '0;
    mst_nbytes = '0;
    case (state)
      S_MUX_WR, S_MUX_WAIT: begin
        mst_start  = (state == S_MUX_WR) && !mst_busy;
        mst_addr   = MUX_ADDR;
        mst_wdata  = 8'd1 << gnt;
        mst_nbytes = 2'd1;
      end
      S_PTR_WR, S_PTR_WAIT: begin
        mst_start  = (state == S_PTR_WR) && !mst_busy;
        mst_addr   = ENC_ADDR;
        mst_wdata  = ANGLE_REG;
        mst_nbytes = 2'd1;
      end
      S_RD, S_RD_WAIT: begin
        mst_start  = (state == S_RD) && !mst_busy;
        mst_rw     = 1'b1;
        mst_addr   = ENC_ADDR;
        mst_nbytes = 2'd2;
      end
      S_RESP: begin
        ack   = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt;
        angle = angle_q;
      end
      S_FAIL: begin
        ack = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt;
        err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: expected master commands and acks are queued by the
// stimulus and popped by an independent monitor; a small I2C master model answers commands.
module tb_i2c_arbiter;

  localparam int NR = 4;
  localparam int TO = 100;

  logic          clock = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [NR-1:0] ack;
  logic [11:0]   angle;
  logic          err;
  logic          mst_start, mst_rw;
  logic [6:0]    mst_addr;
  logic [7:0]    mst_wdata;
  logic [1:0]    mst_nbytes;
  logic          mst_busy, mst_done, mst_nack;
  logic [15:0]   mst_rdata;

  logic          busy_q;
  logic          hold_busy;
  logic          nack_ptr;
  logic [15:0]   rd_tab [8];

  i2c_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .ack(ack), .angle(angle), .err(err),
    .mst_start(mst_start), .mst_rw(mst_rw), .mst_addr(mst_addr), .mst_wdata(mst_wdata),
    .mst_nbytes(mst_nbytes), .mst_busy(mst_busy), .mst_done(mst_done),
    .mst_nack(mst_nack), .mst_rdata(mst_rdata)
  );

  always #5 clock = ~clock;
  assign mst_busy = busy_q | hold_busy;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [1:0] nbytes;
  } cmd_t;

  typedef struct packed {
    logic [NR-1:0] ack;
    logic [11:0]   angle;
    logic          err;
  } rsp_t;

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  cmd_t mon_c;
  rsp_t mon_r;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_starts = 0;
  int first_start_cyc = -1;
  int ack_cyc  = -1;
  int t_req, s0;

`ifdef I2C_ARB_CHAN_CACHE_EN
  bit m_cache_vld = 1'b0;
  int m_cache_ch  = 0;
`endif

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mk_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d,
                                  input logic [1:0] n);
    cmd_t c;
    c.rw = rw; c.addr = a; c.wdata = d; c.nbytes = n;
    return c;
  endfunction

  function automatic rsp_t mk_rsp(input logic [NR-1:0] a, input logic [11:0] ang, input logic e);
    rsp_t r;
    r.ack = a; r.angle = ang; r.err = e;
    return r;
  endfunction

  // Queue one transaction: mux write (unless cached), pointer write, read (unless the
  // pointer write is NACKed), then the matching ack.
  task automatic push_txn(input int ch, input logic [11:0] exp_angle, input bit fail_ptr,
                          input bit with_rsp);
    bit hit;
    hit = 1'b0;
`ifdef I2C_ARB_CHAN_CACHE_EN
    hit = m_cache_vld && (m_cache_ch == ch);
    m_cache_vld = !fail_ptr;
    m_cache_ch  = ch;
`endif
    if (!hit) exp_cmd.push_back(mk_cmd(1'b0, 7'h70, 8'(1 << ch), 2'd1));
    exp_cmd.push_back(mk_cmd(1'b0, 7'h36, 8'h0E, 2'd1));
    if (!fail_ptr) exp_cmd.push_back(mk_cmd(1'b1, 7'h36, 8'h00, 2'd2));
    if (with_rsp)
      exp_rsp.push_back(mk_rsp(NR'(1 << ch), fail_ptr ? 12'h000 : exp_angle, fail_ptr));
  endtask

  task automatic cache_forget();
`ifdef I2C_ARB_CHAN_CACHE_EN
    m_cache_vld = 1'b0;
`endif
  endtask

  task automatic wait_acks(input int n, input int budget);
    int got = 0;
    int k   = 0;
    while (got < n && k < budget) begin
      @(posedge clock); #1;
      k++;
      if (ack != '0) begin
        got++;
        ack_cyc = cyc;
        req = req & ~ack;
      end
    end
    check("ack_count", got, n);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_angle"}, angle, 0);
    check({tag, "_start"}, mst_start, 0);
    check({tag, "_rw"}, mst_rw, 0);
    check({tag, "_addr"}, mst_addr, 0);
    check({tag, "_wdata"}, mst_wdata, 0);
    check({tag, "_nbytes"}, mst_nbytes, 0);
  endtask

  // Monitor: pops and compares whenever the DUT presents a command or an ack.
  initial forever begin
    @(negedge clock);
    if (mst_start === 1'b1) begin
      n_starts++;
      if (first_start_cyc < 0) first_start_cyc = cyc;
      if (exp_cmd.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_start: got addr %0h rw %0b expected no command", mst_addr, mst_rw);
      end else begin
        mon_c = exp_cmd.pop_front();
        check("cmd_rw", mst_rw, mon_c.rw);
        check("cmd_addr", mst_addr, mon_c.addr);
        check("cmd_nbytes", mst_nbytes, mon_c.nbytes);
        if (!mon_c.rw) check("cmd_wdata", mst_wdata, mon_c.wdata);
      end
    end
    if (ack !== '0) begin
      if (exp_rsp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_ack: got ack %0b expected none", ack);
      end else begin
        mon_r = exp_rsp.pop_front();
        check("rsp_ack", ack, mon_r.ack);
        check("rsp_angle", angle, mon_r.angle);
        check("rsp_err", err, mon_r.err);
      end
    end
  end

  // I2C master model: busy from the cycle after start, done two cycles later.
  initial begin
    logic       m_rw;
    logic [6:0] m_addr;
    logic [7:0] m_wd;
    int         mux_ch;
    busy_q = 1'b0; mst_done = 1'b0; mst_nack = 1'b0; mst_rdata = '0; mux_ch = 0;
    forever begin
      @(negedge clock);
      if (mst_start === 1'b1) begin
        m_rw = mst_rw; m_addr = mst_addr; m_wd = mst_wdata;
        @(posedge clock); #1 busy_q = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        mst_nack = nack_ptr && !m_rw && (m_addr == 7'h36);
        if (!m_rw && m_addr == 7'h70)
          for (int i = 0; i < 8; i++) if (m_wd[i]) mux_ch = i;
        mst_rdata = m_rw ? rd_tab[mux_ch] : 16'h0000;
        mst_done  = 1'b1;
        @(posedge clock); #1;
        mst_done = 1'b0; mst_nack = 1'b0; busy_q = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; hold_busy = 1'b0; nack_ptr = 1'b0;
    for (int i = 0; i < 8; i++) rd_tab[i] = 16'h0000;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_outputs_zero("reset");
    @(posedge clock); #1 reset = 1'b0;

    // Single read from requester 0
    rd_tab[0] = 16'hF5A3;
    @(posedge clock); #1;
    push_txn(0, 12'h5A3, 1'b0, 1'b1);
    first_start_cyc = -1;
    t_req = cyc;
    req = 4'b0001;
    wait_acks(1, 500);
    check("first_start_latency", first_start_cyc - t_req, 2);

    // Round robin from reset: 0,1,2,3 then 0,3
    @(posedge clock); #1 reset = 1'b1; req = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    cache_forget();
    rd_tab[0] = 16'h1234; rd_tab[1] = 16'hABCD; rd_tab[2] = 16'h0FFF; rd_tab[3] = 16'hF000;
    push_txn(0, 12'h234, 1'b0, 1'b1);
    push_txn(1, 12'hBCD, 1'b0, 1'b1);
    push_txn(2, 12'hFFF, 1'b0, 1'b1);
    push_txn(3, 12'h000, 1'b0, 1'b1);
    req = 4'b1111;
    wait_acks(4, 2000);
    rd_tab[0] = 16'h0C01; rd_tab[3] = 16'h7777;
    push_txn(0, 12'hC01, 1'b0, 1'b1);
    push_txn(3, 12'h777, 1'b0, 1'b1);
    req = 4'b1001;
    wait_acks(2, 1000);

    // NACK on the pointer write for requester 2
    nack_ptr = 1'b1;
    push_txn(2, 12'h000, 1'b1, 1'b1);
    req = 4'b0100;
    wait_acks(1, 500);
    nack_ptr = 1'b0;

    // Timeout with the master stuck busy
    @(posedge clock); #1;
    hold_busy = 1'b1;
    exp_rsp.push_back(mk_rsp(4'b0001, 12'h000, 1'b1));
    cache_forget();
    t_req = cyc;
    req = 4'b0001;
    wait_acks(1, 500);
    check("timeout_latency", ack_cyc - t_req, TO + 2);
    hold_busy = 1'b0;

    // Reset during RD_WAIT for requester 0
    @(posedge clock); #1;
    rd_tab[0] = 16'h1111;
    push_txn(0, 12'h111, 1'b0, 1'b0);
    req = 4'b0001;
    for (int k = 0; k < 500; k++) begin
      @(negedge clock);
      if (mst_start === 1'b1 && mst_rw === 1'b1) break;
    end
    @(posedge clock); #1;
    reset = 1'b1; req = '0;
    @(posedge clock);
    @(negedge clock);
    check_outputs_zero("midreset");
    @(posedge clock); #1 reset = 1'b0;
    cache_forget();
    repeat (8) @(posedge clock);
    #1;
    rd_tab[0] = 16'h0ABC; rd_tab[3] = 16'h1DEF;
    push_txn(0, 12'hABC, 1'b0, 1'b1);
    push_txn(3, 12'hDEF, 1'b0, 1'b1);
    req = 4'b1001;
    wait_acks(2, 1000);

    // Back-to-back reads from requester 1
    rd_tab[1] = 16'h3456;
    push_txn(1, 12'h456, 1'b0, 1'b1);
    req = 4'b0010;
    wait_acks(1, 500);
    s0 = n_starts;
    push_txn(1, 12'h456, 1'b0, 1'b1);
    req = 4'b0010;
    wait_acks(1, 500);
`ifdef I2C_ARB_CHAN_CACHE_EN
    check("second_txn_starts", n_starts - s0, 2);
`else
    check("second_txn_starts", n_starts - s0, 3);
`endif

    repeat (5) @(posedge clock);
    @(negedge clock);
    check("cmd_queue_empty", exp_cmd.size(), 0);
    check("rsp_queue_empty", exp_rsp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
